// File: rtl/nbout_psum_ctrl.sv
// Partial-sum controller and buffer for the NFU-2 adder trees: feeds the prior
// partial sums to the final adder, writes results back, and forwards finished groups.
module nbout_psum_ctrl #(
   parameter int N        = 16,
   parameter int Tn       = 16,
   parameter int DEPTH    = 64,
   parameter int AW       = 6,
   parameter int PIPE_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_start,
   input  logic [AW:0]       i_num_groups,
   input  logic [15:0]       i_num_passes,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [N*Tn-1:0]   i_nfu2_out,
   output logic [N*Tn-1:0]   o_nbout,
   output logic [N*Tn-1:0]   o_out,
   output logic              o_out_valid,
   output logic [AW-1:0]     o_out_group,
   output logic              o_busy,
   output logic              o_done
);

   localparam int W = N * Tn;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t          state_q, state_d;
   logic [AW:0]     num_groups_q;
   logic [15:0]     num_passes_q;
   logic [AW-1:0]   grp_q;
   logic [15:0]     pass_q;

   logic            beat;
   logic            beat_first;
   logic            beat_last;
   logic            last_grp;
   logic            pipe_busy;

   logic            vld_p   [PIPE_LAT];
   logic [AW-1:0]   grp_p   [PIPE_LAT];
   logic            first_p [PIPE_LAT];
   logic            last_p  [PIPE_LAT];

   logic            stg_vld;
   logic            stg_first;
   logic            stg_last;
   logic [AW-1:0]   stg_grp;

   logic [W-1:0]    psum_mem [DEPTH];

   assign beat       = i_valid && (state_q == RUN);
   assign beat_first = (pass_q == 16'd0);
   assign beat_last  = (pass_q == num_passes_q - 16'd1);
   assign last_grp   = ({1'b0, grp_q} == num_groups_q - 1'b1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // DRAIN waits until the tag pipe is empty and the last o_out_valid has retired
   always_comb begin
      state_d = state_q;
      o_ready = 1'b0;
      o_busy  = 1'b0;
      o_done  = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_start) begin
               state_d = (i_num_groups != '0 && i_num_passes != '0) ? RUN : DONE;
            end
         end
         RUN: begin
            o_ready = 1'b1;
            o_busy  = 1'b1;
            if (beat && beat_last && last_grp) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            o_busy = 1'b1;
            if (!pipe_busy && !o_out_valid) begin
               state_d = DONE;
            end
         end
         DONE: begin
            o_done  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         num_groups_q <= '0;
         num_passes_q <= '0;
         grp_q        <= '0;
         pass_q       <= '0;
      end else if (state_q == IDLE && i_start) begin
         num_groups_q <= i_num_groups;
         num_passes_q <= i_num_passes;
         grp_q        <= '0;
         pass_q       <= '0;
      end else if (beat) begin
         if (last_grp) begin
            grp_q  <= '0;
            pass_q <= pass_q + 16'd1;
         end else begin
            grp_q  <= grp_q + 1'b1;
         end
      end
   end

   // ---- tag pipe: delays beat tags to line up with NFU-2's final adder ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < PIPE_LAT; i++) begin
            vld_p[i]   <= 1'b0;
            grp_p[i]   <= '0;
            first_p[i] <= 1'b0;
            last_p[i]  <= 1'b0;
         end
      end else begin
         vld_p[0]   <= beat;
         grp_p[0]   <= grp_q;
         first_p[0] <= beat_first;
         last_p[0]  <= beat_last;
         for (int i = 1; i < PIPE_LAT; i++) begin
            vld_p[i]   <= vld_p[i-1];
            grp_p[i]   <= grp_p[i-1];
            first_p[i] <= first_p[i-1];
            last_p[i]  <= last_p[i-1];
         end
      end
   end

   always_comb begin
      pipe_busy = 1'b0;
      for (int i = 0; i < PIPE_LAT; i++) begin
         pipe_busy = pipe_busy | vld_p[i];
      end
   end

   assign stg_vld   = vld_p[PIPE_LAT-1];
   assign stg_grp   = grp_p[PIPE_LAT-1];
   assign stg_first = first_p[PIPE_LAT-1];
   assign stg_last  = last_p[PIPE_LAT-1];

   // ---- stage beat: read prior sum, write back or retire the group ----
   assign o_nbout = (stg_vld && !stg_first) ? psum_mem[stg_grp] : '0;

   // Inner-loop ordering guarantees the write lands before the next read of the same entry
   always_ff @(posedge clk) begin
      if (stg_vld && !stg_last) begin
         psum_mem[stg_grp] <= i_nfu2_out;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_out       <= '0;
         o_out_valid <= 1'b0;
         o_out_group <= '0;
      end else begin
         o_out_valid <= stg_vld && stg_last;
         if (stg_vld && stg_last) begin
            o_out       <= i_nfu2_out;
            o_out_group <= stg_grp;
         end
      end
   end

   a_groups_legal: assert property (@(posedge clk) disable iff (rst)
      (state_q == IDLE && i_start) |-> (i_num_groups <= (AW+1)'(DEPTH)));

endmodule

// File: tb/tb_nbout_psum_ctrl.sv
// Scoreboard bench for nbout_psum_ctrl with a behavioural one-stage NFU-2 around it.
module tb_nbout_psum_ctrl;

   localparam int N     = 16;
   localparam int TN    = 16;
   localparam int DEPTH = 64;
   localparam int AW    = 6;
   localparam int W     = N * TN;

   typedef struct {
      logic [AW-1:0] grp;
      logic [W-1:0]  val;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            i_start = 1'b0;
   logic [AW:0]     i_num_groups = '0;
   logic [15:0]     i_num_passes = '0;
   logic            i_valid = 1'b0;
   logic            o_ready;
   logic [W-1:0]    i_nfu2_out;
   logic [W-1:0]    o_nbout;
   logic [W-1:0]    o_out;
   logic            o_out_valid;
   logic [AW-1:0]   o_out_group;
   logic            o_busy;
   logic            o_done;

   logic [W-1:0]    beat_vec = '0;
   logic [W-1:0]    tree_q = '0;
   logic [W-1:0]    acc_m [DEPTH];
   exp_t            exp_q [$];

   int n_chk = 0;
   int n_fail = 0;
   int cyc_cnt = 0;
   int last_ov_cyc = 0;
   int done_cnt = 0;

   nbout_psum_ctrl #(.N(N), .Tn(TN), .DEPTH(DEPTH), .AW(AW), .PIPE_LAT(1)) dut (
      .clk          (clk),
      .rst          (rst),
      .i_start      (i_start),
      .i_num_groups (i_num_groups),
      .i_num_passes (i_num_passes),
      .i_valid      (i_valid),
      .o_ready      (o_ready),
      .i_nfu2_out   (i_nfu2_out),
      .o_nbout      (o_nbout),
      .o_out        (o_out),
      .o_out_valid  (o_out_valid),
      .o_out_group  (o_out_group),
      .o_busy       (o_busy),
      .o_done       (o_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // NFU-2: one register stage on the tree sum, then the final adder
   always @(posedge clk) tree_q <= beat_vec;

   always_comb begin
      i_nfu2_out = '0;
      for (int l = 0; l < TN; l++) begin
         i_nfu2_out[l*N +: N] = o_nbout[l*N +: N] + tree_q[l*N +: N];
      end
   end

   task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   function automatic logic [W-1:0] add_lanes(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] r;
      r = '0;
      for (int l = 0; l < TN; l++) r[l*N +: N] = a[l*N +: N] + b[l*N +: N];
      return r;
   endfunction

   function automatic logic [W-1:0] make_vec(input int mode, input int g, input int p);
      logic [W-1:0] r;
      logic [N-1:0] v;
      r = '0;
      for (int l = 0; l < TN; l++) begin
         case (mode)
            0:       v = 16'h0010;
            1:       v = 16'h4000;
            default: v = 16'(l*257 + g*55 + p*4660 + 3855);
         endcase
         r[l*N +: N] = v;
      end
      return r;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (o_done) done_cnt++;
         if (o_out_valid) begin
            last_ov_cyc = cyc_cnt;
            if (exp_q.size() == 0) begin
               chk("extra_out", W'(1), W'(0));
            end else begin
               e = exp_q.pop_front();
               chk("out_val", o_out, e.val);
               chk("out_grp", W'(o_out_group), W'(e.grp));
            end
         end
      end
   end

   task automatic run_layer(input int ng, input int np, input int mode, input bit bubble,
                            input int stop_at, input int restart_at);
      int g, p, acc_n, cyc;
      bit nb_pend;
      logic [W-1:0] nb_exp;
      @(posedge clk); #1;
      i_start = 1'b1;
      i_num_groups = ng[AW:0];
      i_num_passes = np[15:0];
      @(posedge clk); #1;
      i_start = 1'b0;
      g = 0; p = 0; acc_n = 0; cyc = 0; nb_pend = 0; nb_exp = '0;
      while (acc_n < ng*np && acc_n != stop_at && cyc < 2000) begin
         i_valid = bubble ? (cyc % 3 == 0) : 1'b1;
         i_start = (restart_at >= 0 && acc_n == restart_at);
         if (i_start) begin
            i_num_groups = 1;
            i_num_passes = 1;
         end
         beat_vec = make_vec(mode, g, p);
         @(negedge clk);
         if (nb_pend) chk("nbout", o_nbout, nb_exp);
         nb_pend = 0;
         if (i_valid && o_ready) begin
            nb_exp = (p == 0) ? '0 : acc_m[g];
            acc_m[g] = (p == 0) ? beat_vec : add_lanes(acc_m[g], beat_vec);
            if (p == np - 1) exp_q.push_back('{grp: g[AW-1:0], val: acc_m[g]});
            nb_pend = 1;
            acc_n++;
            g++;
            if (g == ng) begin
               g = 0;
               p++;
            end
         end
         @(posedge clk); #1;
         cyc++;
      end
      i_valid = 1'b0;
      i_start = 1'b0;
      if (cyc >= 2000) chk("beat_timeout", W'(0), W'(1));
      @(negedge clk);
      if (nb_pend) chk("nbout", o_nbout, nb_exp);
      if (stop_at < 0) chk("ready_drain", W'(o_ready), W'(0));
   endtask

   task automatic wait_done(input bit check_lat);
      bit seen;
      seen = 0;
      for (int k = 0; k < 50 && !seen; k++) begin
         @(negedge clk);
         if (o_done) seen = 1;
      end
      if (!seen) begin
         chk("done_timeout", W'(0), W'(1));
      end else begin
         if (check_lat) chk("done_lat", W'(cyc_cnt - last_ov_cyc), W'(2));
         chk("busy_in_done", W'(o_busy), W'(0));
         chk("q_empty", W'(exp_q.size()), W'(0));
      end
      @(negedge clk);
      chk("done_pulse", W'(o_done), W'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", W'(o_ready), W'(0));
      chk("rst_busy", W'(o_busy), W'(0));
      chk("rst_out_valid", W'(o_out_valid), W'(0));
      chk("rst_out", o_out, W'(0));
      chk("rst_out_group", W'(o_out_group), W'(0));
      chk("rst_done", W'(o_done), W'(0));
      rst = 1'b0;

      // base accumulation, single-group hazard, wrap-around
      run_layer(2, 3, 0, 1'b0, -1, -1);
      wait_done(1'b1);
      run_layer(1, 4, 0, 1'b0, -1, -1);
      wait_done(1'b1);
      run_layer(1, 5, 1, 1'b0, -1, -1);
      wait_done(1'b1);

      // bubbles with lane/group/pass-dependent products
      run_layer(3, 2, 2, 1'b1, -1, -1);
      wait_done(1'b1);

      // i_start during RUN must not disturb the layer
      run_layer(2, 2, 2, 1'b0, -1, 2);
      wait_done(1'b1);

      // degenerate start
      @(posedge clk); #1;
      i_start = 1'b1;
      i_num_groups = 7'd2;
      i_num_passes = 16'd0;
      @(negedge clk);
      chk("degen_ready_idle", W'(o_ready), W'(0));
      @(posedge clk); #1;
      i_start = 1'b0;
      @(negedge clk);
      chk("degen_done", W'(o_done), W'(1));
      chk("degen_ready", W'(o_ready), W'(0));
      @(negedge clk);
      chk("degen_done_end", W'(o_done), W'(0));
      chk("degen_ready_end", W'(o_ready), W'(0));

      // reset during pass 1, then a fresh layer over stale buffer data
      run_layer(4, 3, 2, 1'b0, 6, -1);
      #1;
      rst = 1'b1;
      #1;
      chk("abort_ready", W'(o_ready), W'(0));
      chk("abort_busy", W'(o_busy), W'(0));
      chk("abort_out_valid", W'(o_out_valid), W'(0));
      chk("abort_out", o_out, W'(0));
      chk("abort_out_group", W'(o_out_group), W'(0));
      chk("abort_done", W'(o_done), W'(0));
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (6) @(negedge clk);
      run_layer(1, 1, 0, 1'b0, -1, -1);
      wait_done(1'b1);

      repeat (3) @(negedge clk);
      chk("done_total", W'(done_cnt), W'(7));
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
